// File: rtl/bs_pkg.sv
// Shared types and constants for the Black-Scholes dispatch slice.
package bs_pkg;

   localparam int DATASIZE = 192;

   // Option packet layout as carried on in_packet / eng_packet (MSB first).
   typedef struct packed {
      logic [30:0] opt_id;
      logic        otype;
      logic [31:0] sptprice;
      logic [31:0] strike;
      logic [31:0] rate;
      logic [31:0] volatility;
      logic [31:0] time_r;
   } option_packet_t;

   // EMPTY: hold register free, upstream may push. HOLD: packet waits for a free engine.
   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } sched_state_t;

endpackage

// File: rtl/engine_watchdog.sv
// Per-engine busy watchdog. Counts cycles while the engine is owned and
// raises a combinational expire when the engine has been busy for
// TIMEOUT_CYC cycles without reporting done. A done in the expiry cycle
// suppresses the expire. The owner registers expire into its error pulse
// and clears the engine's busy bit on the same edge.
module engine_watchdog #(
   parameter  int TIMEOUT_CYC = 50,
   localparam int CW          = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          load,
   input  logic          done,
   input  logic          busy,
   output logic          expire,
   output logic [CW-1:0] count
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Expire on the busy cycle that completes TIMEOUT_CYC cycles of ownership.
   always_comb begin
      expire = busy && !done && (cnt_q == CW'(TIMEOUT_CYC - 1));
      cnt_d  = cnt_q;
      if (load || done || expire) begin
         cnt_d = '0;
      end else if (busy) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/bs_dispatch_scheduler.sv
// Dispatches option packets to NUM_ENG pricing engines, round-robin.
// One packet is held at a time; a free engine is granted with a one-cycle
// eng_load strobe and stays busy until its done pulse or watchdog expiry.
// Optional statistics counters are built when BS_DISPATCH_STATS_EN is defined;
// otherwise dispatched_count and timeout_count are tied to zero.
// Handshake: a packet transfers on a rising edge where in_valid && in_ready;
// in_ready depends only on the registered state, never on in_valid.
module bs_dispatch_scheduler #(
   parameter int NUM_ENG     = 4,
   parameter int DATASIZE    = bs_pkg::DATASIZE,
   parameter int TIMEOUT_CYC = 50,
   parameter int CNT_W       = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATASIZE-1:0] in_packet,
   output logic [NUM_ENG-1:0]  eng_load,
   output logic [DATASIZE-1:0] eng_packet,
   input  logic [NUM_ENG-1:0]  eng_done,
   output logic [NUM_ENG-1:0]  busy_mask,
   output logic                timeout_err,
   output logic [CNT_W-1:0]    dispatched_count,
   output logic [CNT_W-1:0]    timeout_count
);

   import bs_pkg::*;

   localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

   sched_state_t        state_q, state_d;
   logic [DATASIZE-1:0] hold_q, hold_d;
   logic [DATASIZE-1:0] eng_packet_q, eng_packet_d;
   logic [NUM_ENG-1:0]  eng_load_q, eng_load_d;
   logic [NUM_ENG-1:0]  busy_q, busy_d;
   logic [PTR_W-1:0]    rr_q, rr_d;
   logic                timeout_err_q, timeout_err_d;

   logic [NUM_ENG-1:0]  done_eff;
   logic [NUM_ENG-1:0]  expire;
   logic [NUM_ENG-1:0]  grant_vec;
   logic [PTR_W-1:0]    pick_idx;
   logic                pick_ok;
   logic                grant;
   logic [WD_W-1:0]     wd_count_unused [NUM_ENG];

   // First set bit of free at or above start, wrapping; MSB of result = found.
   function automatic logic [PTR_W:0] rr_pick(input logic [NUM_ENG-1:0] free,
                                              input logic [PTR_W-1:0]   start);
      logic             found;
      logic [PTR_W-1:0] idx;
      logic [PTR_W-1:0] cand;
      int               j;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_ENG; i++) begin
         j = int'(start) + i;
         if (j >= NUM_ENG) j = j - NUM_ENG;
         cand = PTR_W'(j);
         if (!found && free[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   // Grant decision uses registered busy, so a same-cycle done is not yet eligible.
   always_comb begin
      done_eff           = eng_done & busy_q;
      {pick_ok, pick_idx} = rr_pick(~busy_q, rr_q);
      grant              = (state_q == HOLD) && pick_ok;
      grant_vec          = grant ? ({{(NUM_ENG-1){1'b0}}, 1'b1} << pick_idx) : '0;
   end

   // Next-state: hold register FSM, busy tracking, strobes and round-robin pointer.
   always_comb begin
      state_d       = state_q;
      hold_d        = hold_q;
      eng_packet_d  = eng_packet_q;
      rr_d          = rr_q;
      eng_load_d    = grant_vec;
      busy_d        = (busy_q & ~done_eff & ~expire) | grant_vec;
      timeout_err_d = |expire;
      case (state_q)
         EMPTY: begin
            if (in_valid) begin
               hold_d  = in_packet;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (grant) begin
               eng_packet_d = hold_q;
               rr_d         = (pick_idx == PTR_W'(NUM_ENG - 1)) ? '0 : pick_idx + PTR_W'(1);
               state_d      = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // State and output registers; reset abandons any held packet and ownership.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= EMPTY;
         hold_q        <= '0;
         eng_packet_q  <= '0;
         eng_load_q    <= '0;
         busy_q        <= '0;
         rr_q          <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_q        <= hold_d;
         eng_packet_q  <= eng_packet_d;
         eng_load_q    <= eng_load_d;
         busy_q        <= busy_d;
         rr_q          <= rr_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   for (genvar e = 0; e < NUM_ENG; e++) begin : g_wd
      engine_watchdog #(
         .TIMEOUT_CYC (TIMEOUT_CYC)
      ) u_wd (
         .clock  (clock),
         .reset  (reset),
         .load   (grant_vec[e]),
         .done   (done_eff[e]),
         .busy   (busy_q[e]),
         .expire (expire[e]),
         .count  (wd_count_unused[e])
      );
   end

`ifdef BS_DISPATCH_STATS_EN
   logic [CNT_W-1:0] disp_cnt_q, disp_cnt_d;
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

   // Saturating event counters, updated on the edge that raises the strobe.
   always_comb begin
      disp_cnt_d = disp_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      if (grant && (disp_cnt_q != '1)) disp_cnt_d = disp_cnt_q + CNT_W'(1);
      if (timeout_err_d && (tmo_cnt_q != '1)) tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
   end

   // Counter registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         disp_cnt_q <= '0;
         tmo_cnt_q  <= '0;
      end else begin
         disp_cnt_q <= disp_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
      end
   end

   assign dispatched_count = disp_cnt_q;
   assign timeout_count    = tmo_cnt_q;
`else
   assign dispatched_count = '0;
   assign timeout_count    = '0;
`endif

   assign in_ready    = (state_q == EMPTY);
   assign eng_load    = eng_load_q;
   assign eng_packet  = eng_packet_q;
   assign busy_mask   = busy_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bs_dispatch_scheduler.sv
// Bench for bs_dispatch_scheduler (NUM_ENG=4, TIMEOUT_CYC=50).
// Dispatched packets are checked by a negedge monitor against a scoreboard
// queue filled when each packet is driven.
module tb_bs_dispatch_scheduler;

   localparam int NE  = 4;
   localparam int DW  = 192;
   localparam int TMO = 50;
   localparam int CW  = 16;
`ifdef BS_DISPATCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clock;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_packet;
   logic [NE-1:0] eng_load;
   logic [DW-1:0] eng_packet;
   logic [NE-1:0] eng_done;
   logic [NE-1:0] busy_mask;
   logic          timeout_err;
   logic [CW-1:0] dispatched_count;
   logic [CW-1:0] timeout_count;

   int tests  = 0;
   int errors = 0;

   logic [DW-1:0] exp_q[$];
   logic [NE-1:0] exp_eng_q[$];

   typedef struct {
      logic [DW-1:0] pkt;
      logic [NE-1:0] exp_load;
      logic [NE-1:0] exp_busy;
   } vec_t;
   vec_t tbl[4];

   bs_dispatch_scheduler #(
      .NUM_ENG     (NE),
      .DATASIZE    (DW),
      .TIMEOUT_CYC (TMO),
      .CNT_W       (CW)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_packet        (in_packet),
      .eng_load         (eng_load),
      .eng_packet       (eng_packet),
      .eng_done         (eng_done),
      .busy_mask        (busy_mask),
      .timeout_err      (timeout_err),
      .dispatched_count (dispatched_count),
      .timeout_count    (timeout_count)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      eng_done = '0;
      exp_q.delete();
      exp_eng_q.delete();
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   function automatic logic [DW-1:0] rnd_pkt();
      return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Drives one packet; returns just after the accepting edge.
   task automatic send(input logic [DW-1:0] pkt, input logic [NE-1:0] exp_eng);
      int k;
      k = 0;
      while (!in_ready && k < 100) begin
         step();
         k++;
      end
      if (!in_ready) begin
         tests++;
         errors++;
         $display("FAIL send_ready_wait: in_ready got 0 expected 1 within 100 cycles");
         return;
      end
      in_valid  = 1'b1;
      in_packet = pkt;
      exp_q.push_back(pkt);
      exp_eng_q.push_back(exp_eng);
      step();
      in_valid = 1'b0;
   endtask

   task automatic pulse_done(input logic [NE-1:0] d);
      eng_done = d;
      step();
      eng_done = '0;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clock) begin
      logic [DW-1:0] p;
      logic [NE-1:0] e;
      if (!reset && eng_load !== '0) begin
         if (exp_q.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL unexpected_load: eng_load got %b expected 0000", eng_load);
         end else begin
            p = exp_q.pop_front();
            e = exp_eng_q.pop_front();
            check("dispatch_packet", eng_packet, p);
            check("dispatch_engine", DW'(eng_load), DW'(e));
         end
      end
   end

   // ---------------- test ----------------
   initial begin
      int first_k;
      int pulses;
      int loads;
      logic busy49;
      logic busy50;
      logic [DW-1:0] p0;
      logic [DW-1:0] p4;

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_packet = '0;
      eng_done  = '0;

      tbl[0] = '{rnd_pkt(), 4'b0001, 4'b0001};
      tbl[1] = '{rnd_pkt(), 4'b0010, 4'b0011};
      tbl[2] = '{rnd_pkt(), 4'b0100, 4'b0111};
      tbl[3] = '{rnd_pkt(), 4'b1000, 4'b1111};

      // ---- reset state ----
      do_reset();
      check("rst_in_ready", DW'(in_ready), DW'(1'b1));
      check("rst_busy", DW'(busy_mask), '0);
      check("rst_load", DW'(eng_load), '0);
      check("rst_packet", eng_packet, '0);
      check("rst_timeout_err", DW'(timeout_err), '0);
      check("rst_disp_cnt", DW'(dispatched_count), '0);
      check("rst_tmo_cnt", DW'(timeout_count), '0);

      // ---- single packet latency ----
      p0 = 192'h12345679_3F800000_3F8CCCCD_40000000_40400000_40000000;
      send(p0, 4'b0001);
      check("a_hold_load", DW'(eng_load), '0);
      check("a_hold_ready", DW'(in_ready), '0);
      step();
      check("a_load", DW'(eng_load), DW'(4'b0001));
      check("a_packet", eng_packet, p0);
      check("a_busy", DW'(busy_mask), DW'(4'b0001));
      step();
      check("a_load_clear", DW'(eng_load), '0);
      check("a_packet_hold", eng_packet, p0);
      check("a_disp_cnt", DW'(dispatched_count), STATS ? DW'(1) : '0);
      pulse_done(4'b0001);
      check("a_busy_done", DW'(busy_mask), '0);

      // ---- back-to-back fill, fifth stalls ----
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(tbl[i].pkt, tbl[i].exp_load);
         step();
         check("b_load", DW'(eng_load), DW'(tbl[i].exp_load));
         check("b_busy", DW'(busy_mask), DW'(tbl[i].exp_busy));
      end
      p4 = rnd_pkt();
      send(p4, 4'b0100);
      loads = 0;
      for (int k = 0; k < 3; k++) begin
         if (in_ready !== 1'b0 || eng_load !== '0) loads++;
         step();
      end
      check("b_stall", DW'(loads), '0);
      pulse_done(4'b0100);
      check("b_busy_after_done", DW'(busy_mask), DW'(4'b1011));
      check("b_no_same_cycle", DW'(eng_load), '0);
      step();
      check("b_fifth_load", DW'(eng_load), DW'(4'b0100));
      check("b_fifth_packet", eng_packet, p4);
      check("b_busy_full", DW'(busy_mask), DW'(4'b1111));

      // ---- wrap: rr_ptr=3, engine 3 busy ----
      pulse_done(4'b0111);
      check("c_multi_done", DW'(busy_mask), DW'(4'b1000));
      send(rnd_pkt(), 4'b0001);
      step();
      check("c_wrap_load", DW'(eng_load), DW'(4'b0001));
      send(rnd_pkt(), 4'b0010);
      step();
      check("c_next_load", DW'(eng_load), DW'(4'b0010));
      check("c_busy", DW'(busy_mask), DW'(4'b1011));
      check("c_disp_cnt", DW'(dispatched_count), STATS ? DW'(7) : '0);
      pulse_done(4'b1111);
      check("c_busy_clear", DW'(busy_mask), '0);

      // ---- watchdog expiry on engine 1 ----
      do_reset();
      send(rnd_pkt(), 4'b0001);
      step();
      pulse_done(4'b0001);
      send(rnd_pkt(), 4'b0010);
      step();
      check("d_load", DW'(eng_load), DW'(4'b0010));
      first_k = 0;
      pulses  = 0;
      busy49  = 1'b0;
      busy50  = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         step();
         if (timeout_err === 1'b1) begin
            pulses++;
            if (first_k == 0) first_k = k;
         end
         if (k == 49) busy49 = busy_mask[1];
         if (k == 50) busy50 = busy_mask[1];
      end
      check("d_timeout_cycle", DW'(first_k), DW'(TMO));
      check("d_timeout_pulses", DW'(pulses), DW'(1));
      check("d_busy_before", DW'(busy49), DW'(1'b1));
      check("d_busy_reclaimed", DW'(busy50), '0);
      check("d_tmo_cnt", DW'(timeout_count), STATS ? DW'(1) : '0);
      check("d_disp_cnt", DW'(dispatched_count), STATS ? DW'(2) : '0);

      // ---- done coincides with expiry; done on idle engine ----
      do_reset();
      send(rnd_pkt(), 4'b0001);
      step();
      pulse_done(4'b0001);
      send(rnd_pkt(), 4'b0010);
      step();
      pulses = 0;
      for (int k = 1; k <= 49; k++) begin
         step();
         if (timeout_err === 1'b1) pulses++;
      end
      pulse_done(4'b0010);
      check("e_busy_clear", DW'(busy_mask), '0);
      check("e_no_err", DW'(timeout_err), '0);
      for (int k = 0; k < 60; k++) begin
         step();
         if (timeout_err === 1'b1) pulses++;
      end
      check("e_err_pulses", DW'(pulses), '0);
      pulse_done(4'b1000);
      check("e_idle_done_busy", DW'(busy_mask), '0);
      check("e_idle_done_ready", DW'(in_ready), DW'(1'b1));
      step();
      check("e_idle_done_load", DW'(eng_load), '0);
      check("e_tmo_cnt", DW'(timeout_count), '0);

      // ---- reset while holding with all engines busy ----
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(tbl[i].pkt, tbl[i].exp_load);
         step();
      end
      send(rnd_pkt(), 4'b0001);
      check("f_hold_ready", DW'(in_ready), '0);
      check("f_hold_busy", DW'(busy_mask), DW'(4'b1111));
      #2;
      reset = 1'b1;
      #1;
      check("f_rst_ready", DW'(in_ready), DW'(1'b1));
      check("f_rst_busy", DW'(busy_mask), '0);
      check("f_rst_disp_cnt", DW'(dispatched_count), '0);
      exp_q.delete();
      exp_eng_q.delete();
      step();
      reset = 1'b0;
      loads = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (eng_load !== '0) loads++;
      end
      check("f_no_load_after_reset", DW'(loads), '0);
      check("f_ready_after_reset", DW'(in_ready), DW'(1'b1));

      step();
      check("scoreboard_empty", DW'(exp_q.size()), '0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/bs_dispatch_scheduler.md
Name: bs_dispatch_scheduler

Overview:
- Dispatches 192-bit option packets from the upstream packet source to a pool of NUM_ENG Black-Scholes pricing engines.
- Holds one packet at a time and picks a free engine round-robin. Issues a one-cycle load strobe and tracks each engine as busy until its done pulse arrives.
- A per-engine watchdog reclaims engines that never report done.
- Sits between the packet register stage and the replicated BS datapaths.

Parameters:
- NUM_ENG, 4, number of pricing engines; 2..16.
- DATASIZE, 192, packet width: {opt_id[30:0], otype, sptprice, strike, rate, volatility, time_r}.
- TIMEOUT_CYC, 50, busy cycles allowed before an engine is forcibly reclaimed.
- CNT_W, 16, width of statistics counters.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream packet valid
- in_ready  output  1  scheduler can accept a packet (combinational, = state==EMPTY)
- in_packet  input  DATASIZE  upstream packet
- eng_load  output  NUM_ENG  one-hot load strobe, one cycle
- eng_packet  output  DATASIZE  packet broadcast to all engines; valid while eng_load!=0
- eng_done  input  NUM_ENG  per-engine completion pulses
- busy_mask  output  NUM_ENG  engines currently owned
- timeout_err  output  1  one-cycle pulse when any engine times out
- dispatched_count  output  CNT_W  packets dispatched (see optional feature)
- timeout_count  output  CNT_W  engines reclaimed by watchdog (see optional feature)

Behaviour:
- Reset values:
  - state=EMPTY; eng_load=0; eng_packet=0; busy_mask=0; rr_ptr=0.
  - timeout_err=0; all counters=0; all watchdogs=0.
- FSM EMPTY:
  - in_ready=1.
  - On in_valid, latch in_packet into the hold register at the edge and go to HOLD.
- FSM HOLD:
  - in_ready=0.
  - If any engine is free (~busy_mask), pick the first free index scanning from rr_ptr upward with wrap.
  - At the next edge: eng_load[e]<=1, eng_packet<=hold, busy_mask[e]<=1, rr_ptr<=(e+1) mod NUM_ENG, state<=EMPTY.
  - If no engine is free, stay in HOLD; the packet is never dropped.
- Latency and throughput:
  - Accept at edge t with a free engine gives eng_load high for the cycle following edge t+1.
  - Peak rate is one packet per 2 cycles.
- eng_load and timeout_err are registered and auto-clear after one cycle.
- eng_packet holds its last value after the strobe.
- Completion: eng_done[e] with busy_mask[e]=1 clears busy_mask[e] at that edge. The engine becomes eligible in the HOLD decision of the following cycle, not the same cycle.
- A done pulse on a non-busy engine is ignored.
- Watchdog, per engine:
  - Counter clears on load and on done.
  - Increments each cycle while busy.
  - When the count reaches TIMEOUT_CYC with no done in that cycle: clear busy_mask[e], pulse timeout_err, reset the counter.
  - If done and timeout coincide, done wins and no error is flagged.
- Simultaneous done[e] and a HOLD decision in the same cycle: engine e is not selectable this cycle.
- Multiple done pulses in one cycle are all honoured.
- rr_ptr wraps from NUM_ENG-1 to 0.
- A mid-operation reset abandons the hold packet and busy state immediately. Engines are expected to be reset by the same signal.

Optional Feature:
- BS_DISPATCH_STATS_EN defined:
  - dispatched_count increments on every eng_load strobe.
  - timeout_count increments on every timeout_err.
  - Both saturate at all-ones.
- Macro undefined: both outputs are tied to 0 and no counter flops are synthesized. Ports remain present.

Decomposition:
- Shared package bs_pkg:
  - DATASIZE constant.
  - option_packet_t packed struct (opt_id 31b, otype 1b, five 32b fields).
  - sched_state_t enum {EMPTY, HOLD}.
- Sub-module engine_watchdog (params TIMEOUT_CYC):
  - Inputs: clock, reset, load, done.
  - Outputs: expire pulse and count.
  - Instantiated NUM_ENG times via generate.
- The round-robin pick is an always_comb function in the top module.

Test Plan:
- Single packet 192'h12345679_3F800000_3F8CCCCD_40000000_40400000_40000000 accepted at edge t -> eng_load=4'b0001 after edge t+1, eng_packet equal to input, busy_mask=0001.
- Five back-to-back packets with no dones -> grants to engines 0,1,2,3. The fifth stalls in HOLD with in_ready=0. eng_done[2] pulse -> fifth dispatched to engine 2 two edges later.
- With rr_ptr=3 and engine 3 busy, engines 0-2 free -> grant to engine 0 (wrap). rr_ptr becomes 1.
- Engine 1 loaded and never done -> timeout_err pulses exactly 50 cycles after load, busy_mask[1] clears, timeout_count=1 (STATS_EN).
- eng_done[1] in the same cycle as the watchdog expiry -> busy clears, no timeout_err. A done pulse on idle engine 3 -> no state change.
- Reset asserted while in HOLD with busy_mask=1111 -> in_ready=1, busy_mask=0, counters=0, no eng_load issued after reset release.
